// File: rtl/tiny_io_ctrl.sv
// -----------------------------------------------------------------------------
// tiny_io_ctrl
//   I/O bus controller between the TinyComp core's single I/O port and up to
//   eight peripherals. Each peripheral has a one-entry input holding register.
//   Output words go through a shared in-order FIFO that drains over
//   valid/ready handshakes. The core never stalls. Back-pressure is absorbed
//   here, and losses are reported through sticky flags when status is built in.
//
//   Build option: define TINY_IO_STATUS_EN to map address 15 as the
//   status/control register and to keep the sticky overflow/underflow flags.
//   When it is undefined, address 15 is unmapped and losses are silent.
//
// Ports
//   Ph0            clock, all state updates on the rising edge
//   Reset_n        asynchronous active-low reset
//   IOaddr         core I/O address, only [3:0] decoded
//   InStrobe       core executes an Input instruction (pops the selected device)
//   OutStrobe      core executes an Output instruction (pushes or writes control)
//   OutData        core output word
//   InData         word returned to the core (combinational)
//   InRdy          selected source has data (combinational)
//   dev_in_valid   per-device input word offered
//   dev_in_data    per-device input words, device d at [32d+31:32d]
//   dev_in_ack     per-device accept, high in the cycle the word is captured
//   dev_out_valid  one-hot, FIFO head targets device d
//   dev_out_data   FIFO head data
//   dev_out_ready  per-device accept of the FIFO head
// -----------------------------------------------------------------------------
module tiny_io_ctrl #(
    parameter int NDEV        = 4,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                 Ph0,
    input  logic                 Reset_n,
    input  logic [31:0]          IOaddr,
    input  logic                 InStrobe,
    input  logic                 OutStrobe,
    input  logic [31:0]          OutData,
    output logic [31:0]          InData,
    output logic                 InRdy,
    input  logic [NDEV-1:0]      dev_in_valid,
    input  logic [NDEV*32-1:0]   dev_in_data,
    output logic [NDEV-1:0]      dev_in_ack,
    output logic [NDEV-1:0]      dev_out_valid,
    output logic [31:0]          dev_out_data,
    input  logic [NDEV-1:0]      dev_out_ready
);
    localparam int PW = $clog2(OFIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]  dev;
        logic [31:0] data;
    } ofifo_entry_t;

    // ---------------- address decode ----------------
    logic [3:0] w_addr;
    logic       w_is_dev;
    logic       w_unused_addr;

    assign w_addr        = IOaddr[3:0];
    assign w_is_dev      = (w_addr < 4'(NDEV));
    assign w_unused_addr = ^IOaddr[31:4];

    // ---------------- input holding registers ----------------
    logic [NDEV-1:0] r_hvalid;
    logic [31:0]     r_hdata [NDEV];
    logic            w_sel_hvalid;
    logic [31:0]     w_sel_hdata;
    logic [NDEV-1:0] w_in_pop;

    always_comb begin
        // NOTE: every signal gets a default before the loop so no path infers a latch.
        w_sel_hvalid = 1'b0;
        w_sel_hdata  = '0;
        w_in_pop     = '0;
        for (int d = 0; d < NDEV; d++) begin
            if (w_addr == 4'(d)) begin
                w_sel_hvalid = r_hvalid[d];
                w_sel_hdata  = r_hdata[d];
                w_in_pop[d]  = InStrobe & r_hvalid[d];
            end
        end
    end

    // A register being popped on this edge can take a new word at the same
    // time, which sustains one word per cycle per device.
    assign dev_in_ack = dev_in_valid & (~r_hvalid | w_in_pop);

    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) r_hvalid <= '0;
        else          r_hvalid <= dev_in_ack | (r_hvalid & ~w_in_pop);
    end

    // ---------------- output FIFO ----------------
    ofifo_entry_t    r_mem [OFIFO_DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    ofifo_entry_t    w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;

    assign w_head  = r_mem[r_rd];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(OFIFO_DEPTH));

    always_comb begin
        dev_out_valid = '0;
        for (int d = 0; d < NDEV; d++) begin
            if (!w_empty && (w_head.dev == 3'(d))) dev_out_valid[d] = 1'b1;
        end
    end

    assign dev_out_data = w_empty ? '0 : w_head.data;
    assign w_pop        = |(dev_out_valid & dev_out_ready);
    assign w_push_req   = OutStrobe & w_is_dev;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push       = w_push_req & (~w_full | w_pop);

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: pure data storage is not reset; hvalid and the FIFO count gate every read.
    always_ff @(posedge Ph0) begin
        for (int d = 0; d < NDEV; d++) begin
            if (dev_in_ack[d]) r_hdata[d] <= dev_in_data[32*d +: 32];
        end
        if (w_push) r_mem[r_wr] <= {w_addr[2:0], OutData};
    end

    // ---------------- status / control ----------------
`ifdef TINY_IO_STATUS_EN
    localparam logic [3:0] STATUS_ADDR = 4'hF;

    logic        r_overflow;
    logic        r_underflow;
    logic        w_drop;
    logic        w_underflow_evt;
    logic        w_flag_clr;
    logic [31:0] w_status;

    assign w_drop          = w_push_req & w_full & ~w_pop;
    assign w_underflow_evt = InStrobe & w_is_dev & ~w_sel_hvalid;
    assign w_flag_clr      = OutStrobe & (w_addr == STATUS_ADDR) & OutData[0];

    // A flag event on the same edge as a clear wins, so no loss goes unreported.
    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_drop)               r_overflow  <= 1'b1;
            else if (w_flag_clr)      r_overflow  <= 1'b0;
            if (w_underflow_evt)      r_underflow <= 1'b1;
            else if (w_flag_clr)      r_underflow <= 1'b0;
        end
    end

    assign w_status = {13'd0, w_empty, r_underflow, r_overflow, 3'd0,
                       5'(r_count), 8'(r_hvalid)};
`endif

    // ---------------- core read path ----------------
    always_comb begin
        InRdy  = 1'b0;
        InData = '0;
        if (w_is_dev) begin
            InRdy  = w_sel_hvalid;
            InData = w_sel_hvalid ? w_sel_hdata : '0;
        end
`ifdef TINY_IO_STATUS_EN
        else if (w_addr == STATUS_ADDR) begin
            InRdy  = 1'b1;
            InData = w_status;
        end
`endif
    end

endmodule

// File: tb/tb_tiny_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tiny_io_ctrl
//   Self-checking bench for tiny_io_ctrl (NDEV=4, OFIFO_DEPTH=4). Directed
//   scenarios compare against fixed values. The random phase compares against
//   a behavioural model built from arrays and a queue. Status-register checks
//   are compiled only when TINY_IO_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_tiny_io_ctrl;
    localparam int NDEV  = 4;
    localparam int DEPTH = 4;

    logic              Ph0;
    logic              Reset_n;
    logic [31:0]       IOaddr;
    logic              InStrobe;
    logic              OutStrobe;
    logic [31:0]       OutData;
    logic [31:0]       InData;
    logic              InRdy;
    logic [NDEV-1:0]   dev_in_valid;
    logic [NDEV*32-1:0] dev_in_data;
    logic [NDEV-1:0]   dev_in_ack;
    logic [NDEV-1:0]   dev_out_valid;
    logic [31:0]       dev_out_data;
    logic [NDEV-1:0]   dev_out_ready;

    tiny_io_ctrl #(.NDEV(NDEV), .OFIFO_DEPTH(DEPTH)) dut (
        .Ph0(Ph0), .Reset_n(Reset_n), .IOaddr(IOaddr),
        .InStrobe(InStrobe), .OutStrobe(OutStrobe), .OutData(OutData),
        .InData(InData), .InRdy(InRdy),
        .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data), .dev_in_ack(dev_in_ack),
        .dev_out_valid(dev_out_valid), .dev_out_data(dev_out_data),
        .dev_out_ready(dev_out_ready)
    );

    initial Ph0 = 1'b0;
    always #5 Ph0 = ~Ph0;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural model ----------------
    typedef struct {
        int          dev;
        logic [31:0] data;
    } ent_t;

    bit          m_hv [NDEV];
    logic [31:0] m_hd [NDEV];
    ent_t        m_q  [$];
    bit          m_ovf;
    bit          m_udf;

    function automatic void model_reset();
        for (int d = 0; d < NDEV; d++) begin
            m_hv[d] = 1'b0;
            m_hd[d] = '0;
        end
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    function automatic logic [NDEV-1:0] exp_ack();
        logic [NDEV-1:0] a = '0;
        int s = int'(IOaddr[3:0]);
        for (int d = 0; d < NDEV; d++)
            a[d] = dev_in_valid[d] && (!m_hv[d] || (InStrobe && s == d));
        return a;
    endfunction

`ifdef TINY_IO_STATUS_EN
    function automatic logic [31:0] exp_status();
        int s = 0;
        for (int d = 0; d < NDEV; d++) if (m_hv[d]) s += (1 << d);
        s += m_q.size() * 256;
        if (m_ovf) s += (1 << 16);
        if (m_udf) s += (1 << 17);
        if (m_q.size() == 0) s += (1 << 18);
        return 32'(s);
    endfunction
`endif

    function automatic logic exp_inrdy();
        int s = int'(IOaddr[3:0]);
        if (s < NDEV) return m_hv[s];
`ifdef TINY_IO_STATUS_EN
        if (s == 15) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_indata();
        int s = int'(IOaddr[3:0]);
        if (s < NDEV) return m_hv[s] ? m_hd[s] : 32'd0;
`ifdef TINY_IO_STATUS_EN
        if (s == 15) return exp_status();
`endif
        return 32'd0;
    endfunction

    function automatic logic [NDEV-1:0] exp_out_valid();
        logic [NDEV-1:0] v = '0;
        if (m_q.size() > 0) v[m_q[0].dev] = 1'b1;
        return v;
    endfunction

    // Applies one rising edge to the model using the inputs as driven.
    function automatic void model_step();
        int s;
        logic [NDEV-1:0] ack;
        bit pop;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        s   = int'(IOaddr[3:0]);
        ack = exp_ack();
        pop = (m_q.size() > 0) && dev_out_ready[m_q[0].dev];
`ifdef TINY_IO_STATUS_EN
        if (OutStrobe && s == 15 && OutData[0]) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (InStrobe && s < NDEV && !m_hv[s]) m_udf = 1'b1;
`endif
        if (InStrobe && s < NDEV) m_hv[s] = 1'b0;
        for (int d = 0; d < NDEV; d++) begin
            if (ack[d]) begin
                m_hv[d] = 1'b1;
                m_hd[d] = dev_in_data[32*d +: 32];
            end
        end
        if (pop) void'(m_q.pop_front());
        if (OutStrobe && s < NDEV) begin
            if (m_q.size() < DEPTH) m_q.push_back('{dev: s, data: OutData});
`ifdef TINY_IO_STATUS_EN
            else m_ovf = 1'b1;
`endif
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Ph0);
        model_step();
        @(negedge Ph0);
    endtask

    task automatic idle();
        IOaddr        = 32'd0;
        InStrobe      = 1'b0;
        OutStrobe     = 1'b0;
        OutData       = 32'd0;
        dev_in_valid  = '0;
        dev_in_data   = '0;
        dev_out_ready = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge Ph0);
        #1;
        n_checks++;
        if (InRdy !== 1'b0 || InData !== 32'd0 || dev_in_ack !== '0 || dev_out_valid !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b data=%h ack=%b ov=%b, want 0", InRdy, InData, dev_in_ack, dev_out_valid);
        end
        @(negedge Ph0);
        Reset_n = 1'b1;
        InStrobe = 1'b1;
        #1;
        n_checks++;
        if (InRdy !== 1'b0 || InData !== 32'd0) begin
            n_errors++;
            $display("FAIL empty_read: got rdy=%b data=%h, want 0/0", InRdy, InData);
        end
        tick();
        InStrobe = 1'b0;
`ifdef TINY_IO_STATUS_EN
        IOaddr = 32'hF;
        #1;
        n_checks++;
        if (InRdy !== 1'b1 || InData !== 32'h0006_0000) begin
            n_errors++;
            $display("FAIL underflow_status: got rdy=%b data=%h, want 1/00060000", InRdy, InData);
        end
        OutStrobe = 1'b1;
        OutData   = 32'd1;
        tick();
        OutStrobe = 1'b0;
        #1;
        n_checks++;
        if (InData !== 32'h0004_0000) begin
            n_errors++;
            $display("FAIL flag_clear: got %h, want 00040000", InData);
        end
`endif
    endtask

    task automatic test_input();
        idle();
        dev_in_valid[2]       = 1'b1;
        dev_in_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (dev_in_ack !== 4'b0100) begin
            n_errors++;
            $display("FAIL ack_pulse: got %b, want 0100", dev_in_ack);
        end
        tick();
        #1;
        n_checks++;
        if (dev_in_ack !== 4'b0000) begin
            n_errors++;
            $display("FAIL ack_drop: got %b, want 0000 while valid held", dev_in_ack);
        end
        dev_in_valid = '0;
        IOaddr = 32'd2;
        #1;
        n_checks++;
        if (InRdy !== 1'b1 || InData !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL dev2_read: got rdy=%b data=%h, want 1/deadbeef", InRdy, InData);
        end
        // Pop and refill on the same edge.
        InStrobe = 1'b1;
        dev_in_valid[2] = 1'b1;
        dev_in_data[64 +: 32] = 32'h1234_5678;
        #1;
        n_checks++;
        if (dev_in_ack !== 4'b0100) begin
            n_errors++;
            $display("FAIL refill_ack: got %b, want 0100", dev_in_ack);
        end
        tick();
        dev_in_valid = '0;
        #1;
        n_checks++;
        if (InRdy !== 1'b1 || InData !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL refill_data: got rdy=%b data=%h, want 1/12345678", InRdy, InData);
        end
        tick();
        InStrobe = 1'b0;
        #1;
        n_checks++;
        if (InRdy !== 1'b0 || InData !== 32'd0) begin
            n_errors++;
            $display("FAIL dev2_cleared: got rdy=%b data=%h, want 0/0", InRdy, InData);
        end
    endtask

    task automatic test_overflow();
        idle();
        IOaddr    = 32'd1;
        OutStrobe = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            OutData = 32'(i);
            tick();
        end
        OutStrobe = 1'b0;
`ifdef TINY_IO_STATUS_EN
        IOaddr = 32'hF;
        #1;
        n_checks++;
        if (InData[12:8] !== 5'd4 || InData[16] !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_status: got count=%0d ovf=%b, want 4/1", InData[12:8], InData[16]);
        end
        OutStrobe = 1'b1;
        OutData   = 32'd1;
        tick();
        OutStrobe = 1'b0;
`endif
        dev_out_ready = 4'b0010;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_checks++;
            if (dev_out_valid !== 4'b0010 || dev_out_data !== 32'(i)) begin
                n_errors++;
                $display("FAIL drain_order: got v=%b d=%0d, want 0010/%0d", dev_out_valid, dev_out_data, i);
            end
            tick();
        end
        #1;
        n_checks++;
        if (dev_out_valid !== 4'b0000) begin
            n_errors++;
            $display("FAIL drain_empty: got %b, want 0000", dev_out_valid);
        end
        dev_out_ready = '0;
    endtask

    task automatic test_full_push_pop();
        idle();
        IOaddr    = 32'd1;
        OutStrobe = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            OutData = 32'(i);
            tick();
        end
        OutData       = 32'd14;
        dev_out_ready = 4'b0010;
        tick();
        OutStrobe     = 1'b0;
        dev_out_ready = '0;
`ifdef TINY_IO_STATUS_EN
        IOaddr = 32'hF;
        #1;
        n_checks++;
        if (InData[12:8] !== 5'd4 || InData[16] !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop_status: got count=%0d ovf=%b, want 4/0", InData[12:8], InData[16]);
        end
`endif
        dev_out_ready = 4'b0010;
        for (int i = 11; i <= 14; i++) begin
            #1;
            n_checks++;
            if (dev_out_valid !== 4'b0010 || dev_out_data !== 32'(i)) begin
                n_errors++;
                $display("FAIL full_push_pop_order: got v=%b d=%0d, want 0010/%0d", dev_out_valid, dev_out_data, i);
            end
            tick();
        end
        dev_out_ready = '0;
    endtask

    task automatic test_hol();
        idle();
        OutStrobe = 1'b1;
        IOaddr    = 32'd0;
        OutData   = 32'hA0A0;
        tick();
        IOaddr    = 32'd3;
        OutData   = 32'hB3B3;
        tick();
        OutStrobe     = 1'b0;
        dev_out_ready = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (dev_out_valid !== 4'b0001 || dev_out_data !== 32'hA0A0) begin
                n_errors++;
                $display("FAIL hol_block: got v=%b d=%h, want 0001/a0a0", dev_out_valid, dev_out_data);
            end
            tick();
        end
        dev_out_ready = 4'b1001;
        tick();
        #1;
        n_checks++;
        if (dev_out_valid !== 4'b1000 || dev_out_data !== 32'hB3B3) begin
            n_errors++;
            $display("FAIL hol_release: got v=%b d=%h, want 1000/b3b3", dev_out_valid, dev_out_data);
        end
        tick();
        dev_out_ready = '0;
    endtask

    task automatic test_reset_mid();
        idle();
        dev_in_valid          = 4'b1010;
        dev_in_data[32 +: 32] = 32'h1111;
        dev_in_data[96 +: 32] = 32'h3333;
        IOaddr    = 32'd2;
        OutStrobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            OutData = 32'h20 + 32'(i);
            tick();
            dev_in_valid = '0;
        end
        OutStrobe = 1'b0;
        IOaddr    = 32'd3;
        #1;
        n_checks++;
        if (InRdy !== 1'b1 || dev_out_valid !== 4'b0100) begin
            n_errors++;
            $display("FAIL pre_reset_setup: got rdy=%b v=%b, want 1/0100", InRdy, dev_out_valid);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (dev_out_valid !== '0 || InRdy !== 1'b0 || InData !== 32'd0 || dev_in_ack !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b rdy=%b d=%h ack=%b, want all 0", dev_out_valid, InRdy, InData, dev_in_ack);
        end
        model_reset();
        repeat (2) @(negedge Ph0);
        Reset_n       = 1'b1;
        dev_out_ready = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (dev_out_valid !== '0) begin
                n_errors++;
                $display("FAIL post_reset_no_deliver: got %b, want 0000", dev_out_valid);
            end
            tick();
        end
        dev_out_ready = '0;
    endtask

    task automatic test_random();
        int r;
        logic [3:0] a;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      a = 4'(r % NDEV);
            else if (r < 8) a = 4'hF;
            else            a = 4'($urandom_range(NDEV, 14));
            IOaddr        = ($urandom() & 32'hFFFF_FFF0) | 32'(a);
            InStrobe      = ($urandom_range(0, 9) < 3);
            OutStrobe     = ($urandom_range(0, 9) < 4);
            OutData       = $urandom();
            for (int d = 0; d < NDEV; d++) begin
                dev_in_valid[d]       = ($urandom_range(0, 9) < 4);
                dev_in_data[32*d +: 32] = $urandom();
                dev_out_ready[d]      = ($urandom_range(0, 9) < 4);
            end
            #1;
            n_checks++;
            if (InRdy !== exp_inrdy()) begin
                n_errors++;
                $display("FAIL rand_inrdy cyc %0d: got %b, want %b", cyc, InRdy, exp_inrdy());
            end
            n_checks++;
            if (InData !== exp_indata()) begin
                n_errors++;
                $display("FAIL rand_indata cyc %0d: got %h, want %h", cyc, InData, exp_indata());
            end
            n_checks++;
            if (dev_in_ack !== exp_ack()) begin
                n_errors++;
                $display("FAIL rand_ack cyc %0d: got %b, want %b", cyc, dev_in_ack, exp_ack());
            end
            n_checks++;
            if (dev_out_valid !== exp_out_valid()) begin
                n_errors++;
                $display("FAIL rand_out_valid cyc %0d: got %b, want %b", cyc, dev_out_valid, exp_out_valid());
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if (dev_out_data !== m_q[0].data) begin
                    n_errors++;
                    $display("FAIL rand_out_data cyc %0d: got %h, want %h", cyc, dev_out_data, m_q[0].data);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_input();
        test_overflow();
        test_full_push_pop();
        test_hol();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
